truth_table_extractor: RTL

Drives every input combination into an N-input combinational logic gate under test and samples the gate's output for each one. From those samples it rebuilds the gate's truth table as a 2^N-bit word. It checks gate netlists against their specified truth table: the sequential reader for blocks that are described as input->output case tables. The result is optionally compared with an expected table.

---
 rtl/truth_table_extractor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/truth_table_extractor.sv
// Sequential truth-table reader: walks every input vector of an N_IN-input gate,
// samples its output after a settle delay and assembles the 2^N_IN-bit table.
module truth_table_extractor #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  input  logic [(1<<N_IN)-1:0]   exp_table,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   table_valid,
  output logic                   match
);

  localparam int              TW       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
  localparam logic [7:0]      SETTLE   = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] idx_next;
  logic [7:0]      cnt;
  logic [7:0]      cnt_next;
  logic [N_IN-1:0] dut_in_next;
  logic            busy_next;
  logic            done_next;
  logic [TW-1:0]   table_next;
  logic            valid_next;
  logic            match_next;
  logic            vector_end;

  assign vector_end = (cnt == SETTLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort beats start in IDLE and beats the final sample in DRIVE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (vector_end && (idx == LAST_IDX)) begin
          state_next = DONE;
        end else begin
          state_next = DRIVE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    idx_next    = idx;
    cnt_next    = cnt;
    dut_in_next = dut_in;
    busy_next   = busy;
    done_next   = 1'b0;
    table_next  = table_out;
    valid_next  = table_valid;
    // match follows exp_table every cycle once the table is valid
    if (table_valid) begin
      match_next = (table_out == exp_table);
    end else begin
      match_next = 1'b0;
    end
    case (state)
      IDLE: begin
        dut_in_next = '0;
        busy_next   = 1'b0;
        if (start && !abort) begin
          idx_next   = '0;
          cnt_next   = 8'd0;
          busy_next  = 1'b1;
          valid_next = 1'b0;
          match_next = 1'b0;
        end else begin
          idx_next = idx;
        end
      end
      DRIVE: begin
        if (abort) begin
          idx_next    = '0;
          cnt_next    = 8'd0;
          dut_in_next = '0;
          busy_next   = 1'b0;
          valid_next  = 1'b0;
          match_next  = 1'b0;
        end else if (!vector_end) begin
          cnt_next = cnt + 8'd1;
        end else begin
          table_next[idx] = dut_out;
          if (idx == LAST_IDX) begin
            // compare against the table including the bit captured on this edge
            dut_in_next = '0;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            valid_next  = 1'b1;
            match_next  = (table_next == exp_table);
          end else begin
            idx_next    = idx + 1'b1;
            cnt_next    = 8'd0;
            dut_in_next = idx + 1'b1;
          end
        end
      end
      DONE: begin
        dut_in_next = '0;
        busy_next   = 1'b0;
      end
      default: begin
        idx_next    = '0;
        cnt_next    = 8'd0;
        dut_in_next = '0;
        busy_next   = 1'b0;
        valid_next  = 1'b0;
        match_next  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      cnt         <= 8'd0;
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_out   <= '0;
      table_valid <= 1'b0;
      match       <= 1'b0;
    end else begin
      idx         <= idx_next;
      cnt         <= cnt_next;
      dut_in      <= dut_in_next;
      busy        <= busy_next;
      done        <= done_next;
      table_out   <= table_next;
      table_valid <= valid_next;
      match       <= match_next;
    end
  end

endmodule
